// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back/write-allocate one-word-line cache with true-LRU replacement.
// Optional statistics counters are built only when ASSOC_CACHE_STATS_EN is defined.
//
// state | meaning
// IDLE  | ready for a request, latch it on transfer
// CMP   | tag compare; hit responds, miss picks victim
// WB    | write dirty victim back for MEM_LAT cycles
// FILL  | fetch requested word into victim for MEM_LAT cycles
module assoc_wb_cache #(
    parameter int WAYS     = 2,
    parameter int SET_BITS = 8,
    parameter int WORD_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MEM_LAT  = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_req,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       wb_count
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_W - SET_BITS - 2;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, CMP, WB, FILL} state_t;
    state_t state, state_nxt;

    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
    logic [WORD_W-1:0] data_mem [WAYS][SETS];
    logic [WAYS-1:0]   valid_q  [SETS];
    logic [WAYS-1:0]   dirty_q  [SETS];
    logic [WAY_W-1:0]  age_q    [SETS][WAYS];

    logic [ADDR_W-3:0]   addr_q;
    logic                write_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                missed_q;
    logic [WAY_W-1:0]    victim_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WORD_W-1:0]   rdata_q;

    logic [SET_BITS-1:0] idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim;
    logic [WORD_W-1:0]   hit_rdata;
    logic                addr_lsb_unused;

    assign addr_lsb_unused = ^req_addr[1:0];
    assign idx     = addr_q[SET_BITS-1:0];
    assign req_tag = addr_q[ADDR_W-3:SET_BITS];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tag_mem[w][idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Oldest way by default; any invalid way overrides, lowest index last so it wins.
    always_comb begin
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age_q[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) victim = WAY_W'(w);
        end
    end

    assign hit_rdata  = write_q ? wdata_q : data_mem[hit_way][idx];
    assign resp_rdata = resp_valid ? hit_rdata : rdata_q;
    assign resp_hit   = resp_valid && !missed_q;

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_req      = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = CMP;
            end
            CMP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    state_nxt  = IDLE;
                end else if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                    state_nxt = WB;
                end else begin
                    state_nxt = FILL;
                end
            end
            WB: begin
                mem_req      = 1'b1;
                mem_write_en = 1'b1;
                mem_addr     = {tag_mem[victim_q][idx], idx, 2'b00};
                mem_wdata    = data_mem[victim_q][idx];
                if (cnt_q == '0) state_nxt = FILL;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {addr_q, 2'b00};
                if (cnt_q == '0) state_nxt = CMP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            missed_q <= 1'b0;
            victim_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr[ADDR_W-1:2];
                        write_q  <= req_write;
                        wdata_q  <= req_wdata;
                        missed_q <= 1'b0;
                    end
                end
                CMP: begin
                    if (hit) begin
                        rdata_q <= hit_rdata;
                        if (write_q) dirty_q[idx][hit_way] <= 1'b1;
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way) age_q[idx][w] <= '0;
                            else if (age_q[idx][w] < age_q[idx][hit_way])
                                age_q[idx][w] <= age_q[idx][w] + 1'b1;
                        end
                    end else begin
                        missed_q <= 1'b1;
                        victim_q <= victim;
                        cnt_q    <= CNT_LOAD;
                    end
                end
                WB: begin
                    if (cnt_q == '0) begin
                        dirty_q[idx][victim_q] <= 1'b0;
                        cnt_q                  <= CNT_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FILL: begin
                    if (cnt_q == '0) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == CMP && hit && write_q) data_mem[hit_way][idx] <= wdata_q;
        if (state == FILL && cnt_q == '0) begin
            data_mem[victim_q][idx] <= mem_rdata;
            tag_mem[victim_q][idx]  <= req_tag;
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    logic [31:0] hit_q, miss_q, wb_q;
    logic        cmp_miss;

    // A request can miss only on its first lookup, so missed_q gates double counting.
    assign cmp_miss = (state == CMP) && !hit && !missed_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_q  <= '0;
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            if (resp_hit && hit_q != '1) hit_q <= hit_q + 1'b1;
            if (cmp_miss && miss_q != '1) miss_q <= miss_q + 1'b1;
            if (state == CMP && state_nxt == WB && wb_q != '1) wb_q <= wb_q + 1'b1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Bench for assoc_wb_cache: directed scenarios then random traffic against a recency-list cache model.
module tb_assoc_wb_cache;
    localparam int WAYS = 2, SET_BITS = 4, MEM_LAT = 4, NSET = 16;

    logic        clk = 1'b0, rst_b = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_hit, mem_req, mem_write_en;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata = '0;
    logic [31:0] hit_count, miss_count, wb_count;

    assoc_wb_cache #(.WAYS(WAYS), .SET_BITS(SET_BITS), .WORD_W(32), .ADDR_W(32), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_req(mem_req), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count));

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int n_hit = 0, n_miss = 0, n_wb = 0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
        bit          stable;
    } txn_t;
    txn_t txq[$];
    txn_t cur;
    int   cur_len = 0;

    logic [31:0] mem  [logic [31:0]];
    logic [31:0] gold [logic [31:0]];

    logic [31:0] m_addr  [NSET][WAYS];
    bit          m_dirty [NSET][WAYS];
    int          m_cnt   [NSET];

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction
    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        if (gold.exists(a)) return gold[a];
        return pat(a);
    endfunction

    // Memory: commits a write on its MEM_LAT-th cycle and logs every transaction.
    always @(negedge clk) begin
        if (!rst_b) begin
            cur_len = 0;
        end else if (mem_req) begin
            if (cur_len != 0 && (mem_write_en != cur.we || mem_addr != cur.addr)) begin
                txq.push_back(cur);
                cur_len = 0;
            end
            if (cur_len == 0) begin
                cur.we = mem_write_en; cur.addr = mem_addr; cur.data = mem_wdata; cur.stable = 1'b1;
            end else if (mem_wdata != cur.data) begin
                cur.stable = 1'b0;
            end
            cur_len++;
            cur.len = cur_len;
            if (mem_write_en && cur_len == MEM_LAT) mem[mem_addr] = mem_wdata;
        end else if (cur_len != 0) begin
            txq.push_back(cur);
            cur_len = 0;
        end
        mem_rdata = mem_rd(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NSET; s++) m_cnt[s] = 0;
        n_hit = 0; n_miss = 0; n_wb = 0;
        gold = mem;
        txq.delete();
    endtask

    // Per-set list ordered most-recent first; full set evicts the tail.
    task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                                output bit hit, output bit ev, output logic [31:0] ev_addr,
                                output logic [31:0] ev_data, output logic [31:0] rd);
        int s, pos;
        logic [31:0] a, ta;
        bit td;
        a = {addr[31:2], 2'b00};
        s = int'(addr[5:2]);
        pos = -1;
        for (int i = 0; i < m_cnt[s]; i++) if (m_addr[s][i] == a) pos = i;
        hit = (pos >= 0); ev = 1'b0; ev_addr = '0; ev_data = '0;
        if (!hit) begin
            if (m_cnt[s] == WAYS) begin
                pos = WAYS - 1;
                ev = m_dirty[s][pos];
                ev_addr = m_addr[s][pos];
                ev_data = gold_rd(ev_addr);
            end else begin
                pos = m_cnt[s];
                m_cnt[s]++;
            end
            m_addr[s][pos] = a;
            m_dirty[s][pos] = 1'b0;
        end
        ta = m_addr[s][pos]; td = m_dirty[s][pos];
        for (int i = pos; i > 0; i--) begin
            m_addr[s][i] = m_addr[s][i-1];
            m_dirty[s][i] = m_dirty[s][i-1];
        end
        m_addr[s][0] = ta;
        m_dirty[s][0] = td | wr;
        if (wr) gold[a] = wd;
        rd = wr ? wd : gold_rd(a);
        if (hit) n_hit++; else n_miss++;
        if (ev) n_wb++;
    endtask

    // Called at a negedge with the cache idle; returns at the negedge after the response.
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input bit hold, input logic [31:0] next_addr);
        bit hit, ev;
        logic [31:0] ev_addr, ev_data, exp_rd;
        int exp_lat, lat, waitn, busy_rdy, exp_n;
        txn_t t;
        model_access(wr, addr, wd, hit, ev, ev_addr, ev_data, exp_rd);
        exp_lat = hit ? 1 : (ev ? 2 * MEM_LAT + 2 : MEM_LAT + 2);
        exp_n = (hit ? 0 : 1) + (ev ? 1 : 0);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        waitn = 0;
        while (!req_ready && waitn < 20) begin @(negedge clk); waitn++; end
        chk("accept_wait", 32'(waitn), 32'd0);
        @(posedge clk);
        lat = 0; busy_rdy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                if (hold) begin req_addr = next_addr; req_write = 1'b0; end
                else req_valid = 1'b0;
            end
            if (req_ready) busy_rdy++;
        end while (!resp_valid && lat < 40);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_hit", 32'(resp_hit), 32'(hit));
        chk("busy_ready", 32'(busy_rdy), 32'd0);
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("rdata_hold", resp_rdata, exp_rd);
        chk("txn_count", 32'(txq.size()), 32'(exp_n));
        if (ev && txq.size() > 0) begin
            t = txq.pop_front();
            chk("wb_we", 32'(t.we), 32'd1);
            chk("wb_addr", t.addr, ev_addr);
            chk("wb_data", t.data, ev_data);
            chk("wb_len", 32'(t.len), 32'(MEM_LAT));
            chk("wb_stable", 32'(t.stable), 32'd1);
        end
        if (!hit && txq.size() > 0) begin
            t = txq.pop_front();
            chk("fill_we", 32'(t.we), 32'd0);
            chk("fill_addr", t.addr, {addr[31:2], 2'b00});
            chk("fill_len", 32'(t.len), 32'(MEM_LAT));
        end
        txq.delete();
    endtask

    task automatic check_stats();
`ifdef ASSOC_CACHE_STATS_EN
        chk("hit_count", hit_count, 32'(n_hit));
        chk("miss_count", miss_count, 32'(n_miss));
        chk("wb_count", wb_count, 32'(n_wb));
`else
        chk("hit_count", hit_count, 32'd0);
        chk("miss_count", miss_count, 32'd0);
        chk("wb_count", wb_count, 32'd0);
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_b = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        #2 rst_b = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_hit", 32'(resp_hit), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_write_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        check_stats();
        rst_b = 1'b1;
        model_clear();
        @(negedge clk);

        // Conflict in set 0: dirty 0x040 is the LRU victim of 0x080.
        do_req(1'b0, 32'h000, 32'h0, 1'b0, 32'h0);
        do_req(1'b1, 32'h040, 32'h1234_5678, 1'b0, 32'h0);
        do_req(1'b0, 32'h000, 32'h0, 1'b0, 32'h0);
        do_req(1'b0, 32'h080, 32'h0, 1'b0, 32'h0);
        check_stats();
        do_req(1'b0, 32'h000, 32'h0, 1'b0, 32'h0);

        apply_reset();
        mem[32'h040] = 32'hDEAD_BEEF;
        gold[32'h040] = 32'hDEAD_BEEF;
        do_req(1'b0, 32'h040, 32'h0, 1'b0, 32'h0);
        do_req(1'b0, 32'h043, 32'h0, 1'b0, 32'h0);
        do_req(1'b1, 32'h040, 32'h1234_5678, 1'b0, 32'h0);
        do_req(1'b0, 32'h040, 32'h0, 1'b0, 32'h0);

        // Second request held valid throughout the first one's miss.
        do_req(1'b0, 32'h100, 32'h0, 1'b1, 32'h200);
        do_req(1'b0, 32'h200, 32'h0, 1'b0, 32'h0);

        // Reset pulse in the middle of a fill.
        apply_reset();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h040;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(mem_req && !mem_write_en) && n < 20) begin @(negedge clk); n++; end
        chk("fill_start_wait", 32'(n < 20), 32'd1);
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        chk("midfill_mem_req", 32'(mem_req), 32'd0);
        chk("midfill_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        #2 rst_b = 1'b1;
        model_clear();
        @(negedge clk);
        do_req(1'b0, 32'h040, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 200; i++) begin
            a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 2)) << 2) |
                32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom, 1'b0, 32'h0);
        end
        check_stats();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
